nibbler_fetch_unit: RTL and testbench
=====================================

Name: nibbler_fetch_unit

Overview:
- Instruction fetch/sequencing stage directly downstream of the ProgramCounter.
- Consumes the PC's 12-bit addressOut, drives the program ROM address and latches the 8-bit instruction.
- Drives incPC, notLoadPC and the 12-bit jump target back into the PC.
- Presents the decoded opcode/operand to the execute datapath, with the Nibbler's two-phase fetch/execute rhythm plus a third phase for two-byte jumps.

Parameters:
- ADDR_W, 12: PC/ROM address width.
- DATA_W, 8: ROM word width (opcode[7:4], operand[3:0]).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_addr  input  ADDR_W  current PC value (ProgramCounter addressOut).
- rom_data  input  DATA_W  ROM read data; combinational, valid in the same cycle as rom_addr.
- carry_flag  input  1  ALU carry flag, sampled in JUMP_LO.
- zero_flag  input  1  ALU zero flag, sampled in JUMP_LO.
- stall  input  1  freeze sequencing while high.
- rom_addr  output  ADDR_W  ROM address; always equal to pc_addr.
- incPC  output  1  PC increment request, active-high.
- notLoadPC  output  1  PC load request, active-low.
- addressIn  output  ADDR_W  jump target to the PC.
- opcode  output  4  IR[7:4].
- operand  output  4  IR[3:0].
- exec_valid  output  1  one-cycle pulse: IR holds a non-jump instruction to execute.
- jump_taken  output  1  one-cycle pulse in JUMP_LO when the PC is loaded.

Behaviour:
- Shared package opcodes: JC=4'h0, JNC=4'h1, JZ=4'h2, JNZ=4'h3, J=4'h9. Any of these is a two-byte jump; all other opcodes are single-byte.
- States: FETCH, EXEC, JUMP_LO. Reset state is FETCH.
- Reset values: IR=8'h00, state=FETCH, incPC=0, notLoadPC=1, addressIn=0, exec_valid=0, jump_taken=0.
- rom_addr=pc_addr combinationally in every state.
- FETCH:
  - IR<=rom_data at the clock edge; incPC=1 in this cycle, so the PC advances on the same edge.
  - Next state: JUMP_LO if rom_data[7:4] is a jump opcode, else EXEC.
- EXEC:
  - exec_valid=1; opcode/operand come from IR; incPC=0; notLoadPC=1.
  - Next state: FETCH. Latency is 2 cycles per single-byte instruction.
- JUMP_LO:
  - rom_data is the low address byte.
  - Condition: JC: carry=1. JNC: carry=0. JZ: zero=1. JNZ: zero=0. J: always taken.
  - Taken: addressIn={IR[3:0],rom_data}; notLoadPC=0; incPC=0; jump_taken=1.
  - Not taken: incPC=1 (skip the second byte); notLoadPC=1.
  - Next state: FETCH. A jump takes 2 cycles.
- incPC=1 and notLoadPC=0 are never driven in the same cycle.
- addressIn is 0 whenever notLoadPC=1.
- Wrap-around: PC 12'hFFF + inc wraps to 12'h000. A jump whose first byte sits at 12'hFFF reads its low byte from 12'h000.
- stall=1:
  - State and IR hold; incPC=0; notLoadPC=1; exec_valid=0; jump_taken=0.
  - When stall drops, the held state resumes its normal cycle.
- Reset has priority over stall. Reset mid-jump or mid-exec abandons the instruction with no PC load/increment in the reset cycle.

Optional Feature:
- Macro: FETCH_SELF_JUMP_HALT_EN.
- Defined:
  - Adds register inst_addr, latched from pc_addr in FETCH.
  - Adds output halted (1 bit, reset 0).
  - A taken jump whose target equals inst_addr still loads the PC, then sets halted=1 and enters state HALT.
  - HALT: incPC=0, notLoadPC=1, all pulses 0, held until reset.
- Undefined: no port or state; self-jump loops forever normally.

Decomposition:
- Package nibbler_pkg holds:
  - ADDR_W/DATA_W defaults;
  - opcode localparams (JC, JNC, JZ, JNZ, J);
  - fetch_state_t enum (FETCH, EXEC, JUMP_LO, HALT);
  - function is_jump(opcode).
- One sub-module is natural: nibbler_jump_cond, a combinational opcode+flags→taken evaluator. Everything else stays inline.

Test Plan:
- Reset, then ROM[000]=8'h5A: cycle 1 FETCH with incPC=1; cycle 2 exec_valid=1, opcode=5, operand=A; PC=001.
- ROM[001]=8'h93, ROM[002]=8'h4C (J 0x34C): JUMP_LO drives notLoadPC=0, addressIn=12'h34C, jump_taken=1; next fetch at 34C.
- JZ (ROM[010]=8'h21, ROM[011]=8'h00) with zero_flag=0: incPC=1 in JUMP_LO, no load, next fetch at 012. Same with zero_flag=1: load 12'h100.
- stall=1 for 3 cycles during EXEC: exec_valid and incPC stay 0 and state holds; exec_valid pulses exactly once after release.
- reset asserted in JUMP_LO: next cycle state=FETCH, notLoadPC=1, incPC=0, IR=00. PC at FFF with J at FFF reads low byte from 000.
- FETCH_SELF_JUMP_HALT_EN defined, ROM[020]=8'h90, ROM[021]=8'h20: PC loaded to 020, halted=1, no further incPC until reset.

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared Nibbler fetch-stage types, widths and opcode encodings.
package nibbler_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic [3:0] JC  = 4'h0;
  localparam logic [3:0] JNC = 4'h1;
  localparam logic [3:0] JZ  = 4'h2;
  localparam logic [3:0] JNZ = 4'h3;
  localparam logic [3:0] J   = 4'h9;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    JUMP_LO,
    HALT
  } fetch_state_t;

  function automatic logic is_jump(input logic [3:0] op);
    return op inside {JC, JNC, JZ, JNZ, J};
  endfunction

endpackage

// File: rtl/nibbler_jump_cond.sv
// Combinational branch-condition evaluator: opcode plus ALU flags -> taken.
module nibbler_jump_cond
  import nibbler_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       taken
);

  always_comb begin
    case (opcode)
      JC:      taken = carry_flag;
      JNC:     taken = ~carry_flag;
      JZ:      taken = zero_flag;
      JNZ:     taken = ~zero_flag;
      J:       taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/nibbler_fetch_unit.sv
// Nibbler fetch/execute/jump sequencer sitting between the ProgramCounter and ROM.
// Optional FETCH_SELF_JUMP_HALT_EN: a taken jump onto its own address halts the unit.
module nibbler_fetch_unit
  import nibbler_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              carry_flag,
  input  logic              zero_flag,
  input  logic              stall,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              incPC,
  output logic              notLoadPC,
  output logic [ADDR_W-1:0] addressIn,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic              exec_valid,
  output logic              jump_taken
`ifdef FETCH_SELF_JUMP_HALT_EN
  ,
  output logic              halted
`endif
);

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              cond_taken;
  logic [ADDR_W-1:0] target;

`ifdef FETCH_SELF_JUMP_HALT_EN
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic              halted_q, halted_d;
`endif

  nibbler_jump_cond u_jump_cond (
    .opcode     (ir_q[7:4]),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .taken      (cond_taken)
  );

  assign rom_addr = pc_addr;
  assign opcode   = ir_q[7:4];
  assign operand  = ir_q[3:0];
  assign target   = ADDR_W'({ir_q[3:0], rom_data});

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    incPC      = 1'b0;
    notLoadPC  = 1'b1;
    addressIn  = '0;
    exec_valid = 1'b0;
    jump_taken = 1'b0;
`ifdef FETCH_SELF_JUMP_HALT_EN
    inst_addr_d = inst_addr_q;
    halted_d    = halted_q;
`endif
    if (!stall) begin
      case (state_q)
        FETCH: begin
          ir_d    = rom_data;
          incPC   = 1'b1;
          state_d = is_jump(rom_data[7:4]) ? JUMP_LO : EXEC;
`ifdef FETCH_SELF_JUMP_HALT_EN
          inst_addr_d = pc_addr;
`endif
        end
        EXEC: begin
          exec_valid = 1'b1;
          state_d    = FETCH;
        end
        JUMP_LO: begin
          state_d = FETCH;
          if (cond_taken) begin
            notLoadPC  = 1'b0;
            addressIn  = target;
            jump_taken = 1'b1;
`ifdef FETCH_SELF_JUMP_HALT_EN
            if (target == inst_addr_q) begin
              state_d  = HALT;
              halted_d = 1'b1;
            end
`endif
          end else begin
            incPC = 1'b1;
          end
        end
        default: begin
`ifdef FETCH_SELF_JUMP_HALT_EN
          state_d = HALT;
`else
          state_d = FETCH;
`endif
        end
      endcase
    end
    // Reset cycle must not disturb the PC even though state_q still holds the old phase.
    if (reset) begin
      incPC      = 1'b0;
      notLoadPC  = 1'b1;
      addressIn  = '0;
      exec_valid = 1'b0;
      jump_taken = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ir_q    <= '0;
`ifdef FETCH_SELF_JUMP_HALT_EN
      inst_addr_q <= '0;
      halted_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
`ifdef FETCH_SELF_JUMP_HALT_EN
      inst_addr_q <= inst_addr_d;
      halted_q    <= halted_d;
`endif
    end
  end

`ifdef FETCH_SELF_JUMP_HALT_EN
  assign halted = halted_q;
`endif

endmodule

// File: tb/tb_nibbler_fetch_unit.sv
// Bench for nibbler_fetch_unit: ROM + ProgramCounter model, per-cycle vector table via a scoreboard queue.
module tb_nibbler_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pc_addr;
  logic [7:0]  rom_data;
  logic        carry_flag, zero_flag, stall;
  logic [11:0] rom_addr, addressIn;
  logic        incPC, notLoadPC, exec_valid, jump_taken;
  logic [3:0]  opcode, operand;
`ifdef FETCH_SELF_JUMP_HALT_EN
  logic        halted;
`endif

  logic [7:0]  rom [4096];
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic        rst, stl, c, z;
    logic        inc, nl, ev, jt, hlt;
    logic [11:0] ai, pc;
    logic [7:0]  ir;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   row = 0;

  nibbler_fetch_unit #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_addr    (pc_addr),
    .rom_data   (rom_data),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .stall      (stall),
    .rom_addr   (rom_addr),
    .incPC      (incPC),
    .notLoadPC  (notLoadPC),
    .addressIn  (addressIn),
    .opcode     (opcode),
    .operand    (operand),
    .exec_valid (exec_valid),
    .jump_taken (jump_taken)
`ifdef FETCH_SELF_JUMP_HALT_EN
    ,
    .halted     (halted)
`endif
  );

  always #5 clk = ~clk;

  // ProgramCounter model owned by the bench.
  always @(posedge clk) begin
    if (reset)           pc_addr <= 12'h000;
    else if (!notLoadPC) pc_addr <= addressIn;
    else if (incPC)      pc_addr <= pc_addr + 12'h001;
  end

  assign rom_data = rom[rom_addr];

  function automatic vec_t mk(input logic rst, stl, c, z, inc, nl,
                              input logic [11:0] ai, input logic ev, jt,
                              input logic [7:0] ir, input logic [11:0] pc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.c = c; v.z = z;
    v.inc = inc; v.nl = nl; v.ai = ai; v.ev = ev; v.jt = jt;
    v.ir = ir; v.pc = pc; v.hlt = 1'b0;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      vec_t v;
      v = exp_q.pop_front();
      check("incPC",      row, 16'(incPC),      16'(v.inc));
      check("notLoadPC",  row, 16'(notLoadPC),  16'(v.nl));
      check("addressIn",  row, 16'(addressIn),  16'(v.ai));
      check("exec_valid", row, 16'(exec_valid), 16'(v.ev));
      check("jump_taken", row, 16'(jump_taken), 16'(v.jt));
      check("ir",         row, 16'({opcode, operand}), 16'(v.ir));
      check("pc",         row, 16'(pc_addr),    16'(v.pc));
      check("rom_addr",   row, 16'(rom_addr),   16'(v.pc));
`ifdef FETCH_SELF_JUMP_HALT_EN
      check("halted",     row, 16'(halted),     16'(v.hlt));
`endif
      row++;
    end
  end

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    reset = v.rst; stall = v.stl; carry_flag = v.c; zero_flag = v.z;
    exp_q.push_back(v);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    #1;
    while (exp_q.size() != 0 && n < 4) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'hE0;
    rom[12'h000] = 8'h5A; rom[12'h001] = 8'h93; rom[12'h002] = 8'h4C;
    rom[12'h34C] = 8'h90; rom[12'h34D] = 8'h10;
    rom[12'h010] = 8'h21; rom[12'h011] = 8'h00;
    rom[12'h012] = 8'h21; rom[12'h013] = 8'h00;
    rom[12'h100] = 8'h7E; rom[12'h101] = 8'h05; rom[12'h102] = 8'hC0;
    rom[12'h5C0] = 8'h15; rom[12'h5C1] = 8'h00;
    rom[12'h5C2] = 8'h35; rom[12'h5C3] = 8'h00;
    rom[12'h5C4] = 8'hA3; rom[12'h5C5] = 8'hB7;
    rom[12'h5C6] = 8'h9F; rom[12'h5C7] = 8'hFF;
    rom[12'hFFF] = 8'h90; rom[12'h05A] = 8'h93;

    //              rst stl c z inc nl addressIn ev jt ir     pc
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 12'h000, 0, 0, 8'h00, 12'h000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h00, 12'h000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 12'h000, 1, 0, 8'h5A, 12'h001));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h5A, 12'h001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 12'h34C, 0, 1, 8'h93, 12'h002));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h93, 12'h34C));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 12'h000, 0, 0, 8'h90, 12'h34D));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 12'h010, 0, 1, 8'h90, 12'h34D));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h90, 12'h010));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h21, 12'h011));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h21, 12'h012));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 12'h100, 0, 1, 8'h21, 12'h013));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h21, 12'h100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 12'h000, 1, 0, 8'h7E, 12'h101));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h7E, 12'h101));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 12'h5C0, 0, 1, 8'h05, 12'h102));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h05, 12'h5C0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 12'h000, 0, 0, 8'h15, 12'h5C1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h15, 12'h5C2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 12'h000, 0, 0, 8'h35, 12'h5C3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h35, 12'h5C4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 12'h000, 1, 0, 8'hA3, 12'h5C5));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'hA3, 12'h5C5));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 0, 0, 1, 12'h000, 0, 0, 8'hB7, 12'h5C6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 12'h000, 1, 0, 8'hB7, 12'h5C6));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'hB7, 12'h5C6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 12'hFFF, 0, 1, 8'h9F, 12'h5C7));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h9F, 12'hFFF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 12'h05A, 0, 1, 8'h90, 12'h000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h90, 12'h05A));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 12'h000, 0, 0, 8'h93, 12'h05B));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 12'h000, 0, 0, 8'h00, 12'h000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h00, 12'h000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 12'h000, 1, 0, 8'h5A, 12'h001));

    reset = 1'b1; stall = 1'b0; carry_flag = 1'b0; zero_flag = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) step(tbl[i]);
    drain();

    // Self-jump sequence: J 0x020 from 000, then J 0x020 sitting at 020.
    rom[12'h000] = 8'h90; rom[12'h001] = 8'h20;
    rom[12'h020] = 8'h90; rom[12'h021] = 8'h20;
    step(mk(1, 0, 0, 0, 0, 1, 12'h000, 0, 0, 8'h5A, 12'h001));
    step(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h00, 12'h000));
    step(mk(0, 0, 0, 0, 0, 0, 12'h020, 0, 1, 8'h90, 12'h001));
    step(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h90, 12'h020));
    step(mk(0, 0, 0, 0, 0, 0, 12'h020, 0, 1, 8'h90, 12'h021));
`ifdef FETCH_SELF_JUMP_HALT_EN
    for (int i = 0; i < 3; i++) begin
      vec_t h;
      h = mk(0, 0, 0, 0, 0, 1, 12'h000, 0, 0, 8'h90, 12'h020);
      h.hlt = 1'b1;
      step(h);
    end
    begin
      vec_t h;
      h = mk(1, 0, 0, 0, 0, 1, 12'h000, 0, 0, 8'h90, 12'h020);
      h.hlt = 1'b1;
      step(h);
    end
    step(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h00, 12'h000));
`else
    step(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h90, 12'h020));
    step(mk(0, 0, 0, 0, 0, 0, 12'h020, 0, 1, 8'h90, 12'h021));
    step(mk(0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 8'h90, 12'h020));
`endif
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
